// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared widths, timing constants and FSM state encoding for the Morse serializer
package morse_pkg;

  // Pattern width equals the longest character in units (digit 0 = 21 units)
  localparam int PAT_W_DEF    = 21;
  localparam int LEN_W_DEF    = 5;

  // Clock cycles per Morse time unit: 50 ms at 100 MHz
  localparam int TICK_DIV_DEF = 5_000_000;

  // Short unit time so simulations stay a few hundred cycles long
  localparam int TICK_DIV_SIM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/morse_serializador_if.sv
// rtl/morse_serializador_if.sv - character handshake and Morse output bundle between sequencer and serializer
interface morse_serializador_if #(
  parameter int PAT_W = 21,
  parameter int LEN_W = 5
);

  logic             char_valid;
  logic             char_ready;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             abort;
  logic             tone_out;
  logic             busy;
  logic             done;

  // Character sequencer side
  modport master (
    output char_valid,
    output pattern,
    output length,
    output abort,
    input  char_ready,
    input  tone_out,
    input  busy,
    input  done
  );

  // Serializer side
  modport slave (
    input  char_valid,
    input  pattern,
    input  length,
    input  abort,
    output char_ready,
    output tone_out,
    output busy,
    output done
  );

endinterface

// File: rtl/morse_tick_gen.sv
// rtl/morse_tick_gen.sv - restartable Morse time-unit counter
module morse_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..TICK_DIV-1 and wrap; clear holds the count at zero so a new unit starts aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Tick marks the last cycle of the current time unit
  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/morse_serializador.sv
// rtl/morse_serializador.sv - shifts one character's element pattern out on tone_out, one bit per time unit
module morse_serializador
  import morse_pkg::*;
#(
  parameter int PAT_W    = PAT_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  morse_serializador_if.slave  bus
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] len_eff;
  logic             tone_q, tone_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;
  logic             tick_clear;

  // Lengths beyond the pattern width are clamped to the pattern width
  assign len_eff    = (bus.length > PAT_W_L) ? PAT_W_L : bus.length;
  assign accept     = bus.char_valid && ready_q && (state_q == IDLE);
  assign tick_clear = (state_q != SEND);

  morse_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  // State, shift register, unit counter and all outputs are registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tone_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tone_q    <= tone_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state and next output values; the shift register is kept MSB-aligned so the current bit is always the top bit
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tone_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (len_eff == '0) begin
            state_d = FIN;
          end else begin
            state_d   = SEND;
            shreg_d   = bus.pattern << (PAT_W_L - len_eff);
            bit_cnt_d = len_eff;
            tone_d    = shreg_d[PAT_W-1];
          end
        end
      end
      SEND: begin
        tone_d = tone_q;
        if (tick) begin
          bit_cnt_d = bit_cnt_q - LEN_ONE;
          if (bit_cnt_q == LEN_ONE) begin
            state_d = FIN;
            tone_d  = 1'b0;
          end else begin
            shreg_d = shreg_q << 1;
            tone_d  = shreg_q[PAT_W-2];
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel wins over everything, including an accept in the same cycle
    if (bus.abort) begin
      state_d   = IDLE;
      tone_d    = 1'b0;
      bit_cnt_d = '0;
    end

    ready_d = (state_d == IDLE) && !bus.abort;
    busy_d  = (state_d == SEND);
    done_d  = (state_d == FIN);
  end

  assign bus.char_ready = ready_q;
  assign bus.tone_out   = tone_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_morse_serializador.sv
// tb/tb_morse_serializador.sv - directed self-checking bench for the Morse serializer
module tb_morse_serializador;
  import morse_pkg::*;

  localparam int PAT_W = PAT_W_DEF;
  localparam int LEN_W = LEN_W_DEF;
  localparam int TD    = TICK_DIV_SIM;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  morse_serializador_if #(.PAT_W(PAT_W), .LEN_W(LEN_W)) bus_if ();

  morse_serializador #(
    .PAT_W    (PAT_W),
    .LEN_W    (LEN_W),
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach summary by time %0t", $time);
    $fatal(1);
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_if.char_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_if.char_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_ready: char_ready=%b expected 1 within 200 cycles", name, bus_if.char_ready);
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: tone/busy/done/ready=%b%b%b%b expected 0000",
               bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.char_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge: char_ready=%b expected 0", bus_if.char_ready);
    end
    @(negedge clk);
    checks++;
    if (bus_if.char_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_edge: char_ready=%b expected 1", bus_if.char_ready);
    end
  endtask

  task automatic test_e;
    logic et, eb, ed, er;
    wait_ready("E");
    bus_if.pattern    = 21'b100;
    bus_if.length     = 5'd3;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      et = (k <= 4);
      eb = (k <= 12);
      ed = (k == 13);
      er = (k == 14);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {et, eb, ed, er}) begin
        errors++;
        $display("FAIL E cycle %0d: tone/busy/done/ready=%b%b%b%b expected %b%b%b%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, et, eb, ed, er);
      end
    end
  endtask

  task automatic test_a;
    logic [6:0] a_units;
    logic et, eb, ed, er;
    a_units = 7'b1011100;
    wait_ready("A");
    bus_if.pattern    = 21'b1011100;
    bus_if.length     = 5'd7;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      et = (k <= 28) ? a_units[6 - (k - 1) / TD] : 1'b0;
      eb = (k <= 28);
      ed = (k == 29);
      er = (k == 30);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {et, eb, ed, er}) begin
        errors++;
        $display("FAIL A cycle %0d: tone/busy/done/ready=%b%b%b%b expected %b%b%b%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, et, eb, ed, er);
      end
    end
  endtask

  task automatic test_unsupported;
    logic et, eb, ed, er;
    wait_ready("len0");
    bus_if.pattern    = 21'b101;
    bus_if.length     = 5'd0;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      ed = (k == 1);
      er = (k == 2);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {1'b0, 1'b0, ed, er}) begin
        errors++;
        $display("FAIL len0 cycle %0d: tone/busy/done/ready=%b%b%b%b expected 00%b%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, ed, er);
      end
    end
    wait_ready("len31");
    bus_if.pattern    = '1;
    bus_if.length     = 5'd31;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    for (int k = 1; k <= 86; k++) begin
      @(negedge clk);
      et = (k <= 84);
      eb = (k <= 84);
      ed = (k == 85);
      er = (k == 86);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {et, eb, ed, er}) begin
        errors++;
        $display("FAIL len31 cycle %0d: tone/busy/done/ready=%b%b%b%b expected %b%b%b%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, et, eb, ed, er);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic et, eb, ed, er;
    int   done_seen;
    done_seen = 0;
    wait_ready("b2b");
    bus_if.pattern    = 21'b100;
    bus_if.length     = 5'd3;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.pattern = 21'b11100;
    bus_if.length  = 5'd5;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      et = (k <= 4) || (k >= 15 && k <= 26);
      eb = (k <= 12) || (k >= 15 && k <= 34);
      ed = (k == 13) || (k == 35);
      er = (k == 14) || (k == 36);
      if (bus_if.done === 1'b1) done_seen++;
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {et, eb, ed, er}) begin
        errors++;
        $display("FAIL b2b cycle %0d: tone/busy/done/ready=%b%b%b%b expected %b%b%b%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, et, eb, ed, er);
      end
      if (k == 14) begin
        @(posedge clk);
        #1 bus_if.char_valid = 1'b0;
      end
    end
    checks++;
    if (done_seen != 2) begin
      errors++;
      $display("FAIL b2b_done_count: saw %0d done pulses expected 2", done_seen);
    end
  endtask

  task automatic test_abort;
    logic [6:0] a_units;
    logic et, eb, er;
    a_units = 7'b1011100;
    wait_ready("abort");
    bus_if.pattern    = 21'b1011100;
    bus_if.length     = 5'd7;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      et = (k <= 6) ? a_units[6 - (k - 1) / TD] : 1'b0;
      eb = (k <= 6);
      er = (k >= 8);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {et, eb, 1'b0, er}) begin
        errors++;
        $display("FAIL abort cycle %0d: tone/busy/done/ready=%b%b%b%b expected %b%b0%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, et, eb, er);
      end
      if (k == 6) begin
        bus_if.abort = 1'b1;
        @(posedge clk);
        #1 bus_if.abort = 1'b0;
      end
    end
    bus_if.pattern    = 21'b100;
    bus_if.length     = 5'd3;
    bus_if.char_valid = 1'b1;
    bus_if.abort      = 1'b1;
    @(posedge clk);
    #1;
    bus_if.char_valid = 1'b0;
    bus_if.abort      = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      er = (k >= 2);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {3'b000, er}) begin
        errors++;
        $display("FAIL abort_vs_accept cycle %0d: tone/busy/done/ready=%b%b%b%b expected 000%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, er);
      end
    end
  endtask

  task automatic test_async_reset;
    logic et, eb, ed, er;
    wait_ready("areset");
    bus_if.pattern    = 21'b100;
    bus_if.length     = 5'd3;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus_if.tone_out, bus_if.busy} !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre: tone/busy=%b%b expected 11", bus_if.tone_out, bus_if.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: tone/busy/done/ready=%b%b%b%b expected 0000",
               bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_release: tone/busy/done/ready=%b%b%b%b expected 0000",
               bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready);
    end
    @(negedge clk);
    checks++;
    if (bus_if.char_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_ready: char_ready=%b expected 1", bus_if.char_ready);
    end
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      et = (k <= 4);
      eb = (k <= 12);
      ed = (k == 13);
      er = (k == 14);
      checks++;
      if ({bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready} !== {et, eb, ed, er}) begin
        errors++;
        $display("FAIL areset_E cycle %0d: tone/busy/done/ready=%b%b%b%b expected %b%b%b%b", k,
                 bus_if.tone_out, bus_if.busy, bus_if.done, bus_if.char_ready, et, eb, ed, er);
      end
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus_if.char_valid = 1'b0;
    bus_if.pattern    = '0;
    bus_if.length     = '0;
    bus_if.abort      = 1'b0;
    test_reset;
    test_e;
    test_a;
    test_unsupported;
    test_back_to_back;
    test_abort;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
